// File: rtl/pulse_code_pkg.sv
// Shared types and defaults for the pulse-code transmitter: state encoding,
// default mark/gap durations and the burst length limit.
package pulse_code_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MARK = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_SHORT_CYC = 10_000_000;
  localparam int DEF_LONG_CYC  = 60_000_000;
  localparam int DEF_GAP_CYC   = 10_000_000;
  localparam int MAX_SYM       = 8;

  // Requests longer than the symbol register are clamped rather than rejected.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > 4'(MAX_SYM)) ? 4'(MAX_SYM) : len;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter that times marks and gaps; holds at zero, never wraps.
module pulse_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_code_tx.sv
// Burst encoder: sends up to 8 symbols as short (0) / long (1) high marks on
// out_line, each followed by a fixed low gap, then pulses done.
module pulse_code_tx
  import pulse_code_pkg::*;
#(
  parameter int SHORT_CYC = DEF_SHORT_CYC,
  parameter int LONG_CYC  = DEF_LONG_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int CNT_W     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_sym,
  input  logic [3:0] in_len,
  input  logic       abort,
  output logic       out_line,
  output logic       busy,
  output logic       done
);

  // Handshake: a burst is taken at the clock edge where in_valid && in_ready;
  // in_ready is high only in IDLE, so the requester holds in_valid until then.

  localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  state_t           state;
  logic [7:0]       sym_reg;
  logic [3:0]       remaining;
  logic [3:0]       len_c;
  logic             accept;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;

  assign len_c  = clamp_len(in_len);
  assign accept = in_valid && (state == ST_IDLE);

  always_comb begin
    load     = 1'b0;
    load_val = GAP_LD;
    case (state)
      ST_IDLE: begin
        if (accept && (len_c != 4'd0)) begin
          load     = 1'b1;
          load_val = in_sym[0] ? LONG_LD : SHORT_LD;
        end
      end
      ST_MARK: begin
        if (!abort && zero) begin
          load     = 1'b1;
          load_val = GAP_LD;
        end
      end
      ST_GAP: begin
        // sym_reg was shifted on leaving MARK, so bit 0 is the next symbol.
        if (!abort && zero && (remaining != 4'd0)) begin
          load     = 1'b1;
          load_val = sym_reg[0] ? LONG_LD : SHORT_LD;
        end
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sym_reg   <= '0;
      remaining <= '0;
      out_line  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sym_reg <= in_sym;
            if (len_c == 4'd0) begin
              done <= 1'b1;
            end else begin
              state     <= ST_MARK;
              remaining <= len_c;
              out_line  <= 1'b1;
              busy      <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end
        ST_MARK: begin
          if (abort) begin
            state     <= ST_IDLE;
            sym_reg   <= '0;
            remaining <= '0;
            out_line  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end else if (zero) begin
            state     <= ST_GAP;
            sym_reg   <= sym_reg >> 1;
            remaining <= remaining - 4'd1;
            out_line  <= 1'b0;
          end
        end
        ST_GAP: begin
          if (abort) begin
            state     <= ST_IDLE;
            sym_reg   <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end else if (zero) begin
            if (remaining != 4'd0) begin
              state    <= ST_MARK;
              out_line <= 1'b1;
            end else begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              in_ready <= 1'b1;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          out_line <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_code_tx.sv
// Self-checking bench for pulse_code_tx with scaled durations (4/10/3 cycles):
// per-cycle vector table plus hand-written reset, overlong, abort sequences.
module tb_pulse_code_tx;

  localparam int SHORT = 4;
  localparam int LONG  = 10;
  localparam int GAP   = 3;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sym;
  logic [3:0] in_len;
  logic       abort;
  logic       out_line;
  logic       busy;
  logic       done;

  pulse_code_tx #(
    .SHORT_CYC (SHORT),
    .LONG_CYC  (LONG),
    .GAP_CYC   (GAP),
    .CNT_W     (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sym   (in_sym),
    .in_len   (in_len),
    .abort    (abort),
    .out_line (out_line),
    .busy     (busy),
    .done     (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Mark-width monitor; widths >= LONG classify as a long press event.
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] ev_q[$];
  int          width = 0;
  logic        prev_line = 1'b0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      width     = 0;
      prev_line = 1'b0;
    end else begin
      if (out_line) begin
        width = width + 1;
      end else if (prev_line) begin
        got_q.push_back(32'(width));
        ev_q.push_back((width >= LONG) ? 32'd1 : 32'd0);
        width = 0;
      end
      prev_line = out_line;
      if (done) done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic check_widths(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_width"}, got_q[i], exp_q[i]);
  endtask

  typedef struct {
    logic       valid;
    logic [7:0] sym;
    logic [3:0] len;
    logic       abt;
    logic       e_line;
    logic       e_busy;
    logic       e_done;
    logic       e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input logic v, input logic [7:0] s,
                              input logic [3:0] l, input logic a, input logic el,
                              input logic eb, input logic ed, input logic er);
    vec_t x;
    x.valid = v; x.sym = s; x.len = l; x.abt = a;
    x.e_line = el; x.e_busy = eb; x.e_done = ed; x.e_ready = er;
    for (int i = 0; i < n; i++) vecs.push_back(x);
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sym   = '0;
    in_len   = '0;
    abort    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_line", 32'(out_line), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();

    // Vector table: each row = inputs before an edge, outputs after it.
    // Two-symbol burst 8'b10: 4 high, 3 low, 10 high, 3 low, done.
    add(1,  1'b1, 8'b10, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(3,  1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(3,  1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(10, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(3,  1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1,  1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1,  1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Zero-length burst: done next cycle, nothing on the line.
    add(1,  1'b1, 8'h55, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(2,  1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Abort alone in IDLE does nothing.
    add(2,  1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Abort together with valid in IDLE: the accept wins (one short symbol).
    add(1,  1'b1, 8'h00, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(3,  1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(3,  1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1,  1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1,  1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    got_q.delete();
    ev_q.delete();
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].valid;
      in_sym   = vecs[i].sym;
      in_len   = vecs[i].len;
      abort    = vecs[i].abt;
      step();
      check($sformatf("vec%0d_line", i), 32'(out_line), 32'(vecs[i].e_line));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    exp_q = '{32'(SHORT), 32'(LONG), 32'(SHORT)};
    check_widths("table");
    // Loopback view: a short press, then a long press, then a short press.
    check("event_count", 32'(ev_q.size()), 32'd3);
    if (ev_q.size() >= 2) begin
      check("event0_short", ev_q[0], 32'd0);
      check("event1_long", ev_q[1], 32'd1);
    end

    // Overlong request clamps to 8 long marks; a mid-burst request is ignored.
    got_q.delete();
    done_cnt = 0;
    in_valid = 1'b1; in_sym = 8'hFF; in_len = 4'd12;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    in_valid = 1'b1; in_sym = 8'hFF; in_len = 4'd1;
    step();
    check("ignored_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_done(200, "clamp_done_seen");
    repeat (6) step();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(LONG));
    check_widths("clamp");
    check("clamp_done_cnt", 32'(done_cnt), 32'd1);
    check("clamp_idle_line", 32'(out_line), 32'd0);

    // Abort on the 3rd high cycle of the first mark, then a fresh long burst.
    got_q.delete();
    done_cnt = 0;
    in_valid = 1'b1; in_sym = 8'b1; in_len = 4'd3;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("abort_pre_line", 32'(out_line), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_line", 32'(out_line), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (15) step();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    in_valid = 1'b1; in_sym = 8'b1; in_len = 4'd1;
    step();
    in_valid = 1'b0;
    wait_done(50, "after_abort_done_seen");
    step();
    exp_q = '{32'd3, 32'(LONG)};
    check_widths("abort");
    check("after_abort_done_cnt", 32'(done_cnt), 32'd1);

    // Asynchronous reset in the middle of a mark.
    got_q.delete();
    done_cnt = 0;
    in_valid = 1'b1; in_sym = 8'b00; in_len = 4'd2;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_line", 32'(out_line), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_ready", 32'(in_ready), 32'd1);
    check("midreset_done", 32'(done), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (8) step();
    check("postreset_line", 32'(out_line), 32'd0);
    check("postreset_busy", 32'(busy), 32'd0);
    check("postreset_ready", 32'(in_ready), 32'd1);
    check("postreset_no_done", 32'(done_cnt), 32'd0);
    check("postreset_no_marks", 32'(got_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
